// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator: h/v counters, a registered stage-0
// decode, and a delay line that aligns HS/VS/BLANK with pixel data LATENCY cycles later.
module vga_timing_gen #(
  parameter int HDISP   = 640,
  parameter int HFP     = 16,
  parameter int HPULSE  = 96,
  parameter int HBP     = 48,
  parameter int VDISP   = 480,
  parameter int VFP     = 10,
  parameter int VPULSE  = 2,
  parameter int VBP     = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int LATENCY = 0,
  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1,
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          PIX_REQ,
  output logic [XW-1:0] PIX_X,
  output logic [YW-1:0] PIX_Y,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HCW    = $clog2(HTOTAL);
  localparam int VCW    = $clog2(VTOTAL);

  localparam logic [HCW-1:0] H_LAST = HCW'(HTOTAL - 1);
  localparam logic [HCW-1:0] H_DISP = HCW'(HDISP);
  localparam logic [HCW-1:0] H_PS   = HCW'(HDISP + HFP);
  localparam logic [HCW-1:0] H_PE   = HCW'(HDISP + HFP + HPULSE);
  localparam logic [VCW-1:0] V_LAST = VCW'(VTOTAL - 1);
  localparam logic [VCW-1:0] V_DISP = VCW'(VDISP);
  localparam logic [VCW-1:0] V_PS   = VCW'(VDISP + VFP);
  localparam logic [VCW-1:0] V_PE   = VCW'(VDISP + VFP + VPULSE);

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           h_wrap, h_vis, v_vis, h_pulse, v_pulse;

  logic          pix_req_q, line_start_q, frame_start_q;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  logic          hs0_q, vs0_q, blank0_q;

  always_comb begin
    h_wrap  = (hc_q == H_LAST);
    hc_d    = h_wrap ? '0 : hc_q + HCW'(1);
    vc_d    = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + VCW'(1);
    end
    h_vis   = (hc_q < H_DISP);
    v_vis   = (vc_q < V_DISP);
    h_pulse = (hc_q >= H_PS) && (hc_q < H_PE);
    v_pulse = (vc_q >= V_PS) && (vc_q < V_PE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hc_q          <= '0;
      vc_q          <= '0;
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs0_q         <= ~HS_POL;
      vs0_q         <= ~VS_POL;
      blank0_q      <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      pix_req_q     <= h_vis && v_vis;
      pix_x_q       <= h_vis ? hc_q[XW-1:0] : '0;
      pix_y_q       <= v_vis ? vc_q[YW-1:0] : '0;
      line_start_q  <= (hc_q == '0);
      frame_start_q <= (hc_q == '0) && (vc_q == '0);
      hs0_q         <= h_pulse ? HS_POL : ~HS_POL;
      vs0_q         <= v_pulse ? VS_POL : ~VS_POL;
      blank0_q      <= h_vis && v_vis;
    end
  end

  // Every delay stage resets to the inactive levels so no stale pulse survives a reset.
  generate
    if (LATENCY == 0) begin : g_nodelay
      assign VGA_HS    = hs0_q;
      assign VGA_VS    = vs0_q;
      assign VGA_BLANK = blank0_q;
    end else begin : g_delay
      logic [LATENCY-1:0] hs_dl_q, hs_dl_d;
      logic [LATENCY-1:0] vs_dl_q, vs_dl_d;
      logic [LATENCY-1:0] blank_dl_q, blank_dl_d;

      for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          assign hs_dl_d[gi]    = hs0_q;
          assign vs_dl_d[gi]    = vs0_q;
          assign blank_dl_d[gi] = blank0_q;
        end else begin : g_next
          assign hs_dl_d[gi]    = hs_dl_q[gi-1];
          assign vs_dl_d[gi]    = vs_dl_q[gi-1];
          assign blank_dl_d[gi] = blank_dl_q[gi-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          hs_dl_q    <= {LATENCY{~HS_POL}};
          vs_dl_q    <= {LATENCY{~VS_POL}};
          blank_dl_q <= '0;
        end else begin
          hs_dl_q    <= hs_dl_d;
          vs_dl_q    <= vs_dl_d;
          blank_dl_q <= blank_dl_d;
        end
      end

      assign VGA_HS    = hs_dl_q[LATENCY-1];
      assign VGA_VS    = vs_dl_q[LATENCY-1];
      assign VGA_BLANK = blank_dl_q[LATENCY-1];
    end
  endgenerate

  assign PIX_REQ     = pix_req_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign VGA_CLK     = CLK;
  assign VGA_SYNC    = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator. It is the successor of the fixed 640x480 sync generator, and sits between the pixel clock domain and the video DAC. It produces HS/VS/BLANK with programmable porches and sync polarities, and emits pixel coordinates plus frame/line strobes for the upstream pixel pipeline. Sync and blank outputs are delayed by a programmable pipeline latency so they align with pixel data produced LATENCY cycles after each request.

## Interface
- HDISP, 640: visible pixels per line (≥1)
- HFP, 16: horizontal front porch, pixel clocks (≥1)
- HPULSE, 96: horizontal sync pulse width (≥1)
- HBP, 48: horizontal back porch (≥1)
- VDISP, 480: visible lines per frame (≥1)
- VFP, 10: vertical front porch, lines (≥1)
- VPULSE, 2: vertical sync pulse width, lines (≥1)
- VBP, 33: vertical back porch, lines (≥1)
- HS_POL, 0: active level of VGA_HS during its pulse
- VS_POL, 0: active level of VGA_VS during its pulse
- LATENCY, 0: extra cycles by which VGA_HS/VGA_VS/VGA_BLANK lag the pixel request outputs (0..16)

Ports:
- CLK  in  1  pixel clock
- RST  in  1  reset, synchronous, active-high
- PIX_REQ  out  1  coordinate is visible; pixel data wanted
- PIX_X  out  $clog2(HDISP)  visible column, 0..HDISP-1
- PIX_Y  out  $clog2(VDISP)  visible line, 0..VDISP-1
- LINE_START  out  1  one-cycle strobe at column 0 of every line (visible or not)
- FRAME_START  out  1  one-cycle strobe at column 0, line 0
- VGA_CLK  out  1  equals CLK (combinational pass-through)
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK  out  1  1 = visible region (DAC BLANK_N semantics)
- VGA_SYNC  out  1  constant 0

## Operation
- HTOTAL = HDISP+HFP+HPULSE+HBP and VTOTAL = VDISP+VFP+VPULSE+VBP.
- Internal counters: hc (0..HTOTAL-1) and vc (0..VTOTAL-1), widths $clog2(HTOTAL) and $clog2(VTOTAL).
  - hc increments every cycle and wraps to 0 after HTOTAL-1.
  - vc increments when hc wraps, and wraps to 0 after VTOTAL-1.
- Region order on both axes: display, front porch, pulse, back porch.
  - Horizontal pulse is active for hc in [HDISP+HFP, HDISP+HFP+HPULSE-1].
  - Vertical pulse is active for vc in [VDISP+VFP, VDISP+VFP+VPULSE-1], the full line including porches. VS edges therefore coincide with hc=0.
- Visible means hc<HDISP and vc<VDISP.
- Stage-0 decode from (hc,vc) is registered into the request outputs:
  - PIX_REQ = visible.
  - PIX_X = hc when hc<HDISP, else 0.
  - PIX_Y = vc when vc<VDISP, else 0.
  - LINE_START = (hc==0).
  - FRAME_START = (hc==0 && vc==0).
- Registered stage-0 hs/vs/blank pass through a LATENCY-deep shift register before reaching VGA_HS/VGA_VS/VGA_BLANK.
- VGA_HS = HS_POL during the pulse, otherwise ~HS_POL. VGA_VS likewise with VS_POL.
- No handshake: PIX_REQ is a demand. The upstream block must present data exactly LATENCY cycles later.

## Timing
- Reset, applied on any edge with RST=1:
  - hc=0, vc=0.
  - PIX_REQ=0, PIX_X=0, PIX_Y=0, LINE_START=0, FRAME_START=0.
  - VGA_BLANK=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - Every delay-line stage is cleared to these same inactive values.
- First edge with RST=0: the outputs take the decode of (0,0), so PIX_REQ=1, FRAME_START=1, LINE_START=1, X=0, Y=0. Counters move to (1,0).
- Latency:
  - Request outputs lag the counters by 1 cycle.
  - VGA_HS/VS/BLANK lag the request outputs by exactly LATENCY cycles.
  - With LATENCY=0, VGA_BLANK equals PIX_REQ cycle for cycle.
- Reset mid-frame: same single-edge effect as above. The raster restarts at (0,0), and FRAME_START is asserted on the first edge after RST falls. No partial pulse from the delay line may appear after reset.
- Wrap: hc=HTOTAL-1 with vc=VTOTAL-1 goes to (0,0) on the next edge. There are no idle cycles between frames.
- Period checks: LINE_START repeats every HTOTAL cycles. FRAME_START repeats every HTOTAL*VTOTAL cycles.

## Test plan
All scenarios use the small configuration HDISP=4, HFP=1, HPULSE=2, HBP=1, VDISP=3, VFP=1, VPULSE=1, VBP=1, LATENCY=2, POL=0 unless stated (HTOTAL=8, VTOTAL=6).
- Reset: hold RST for 3 cycles, then release.
  - Required during reset: all outputs at their reset values.
  - Required on the first edge after release: PIX_REQ=1, FRAME_START=1, X=0.
  - Required 2 edges later: VGA_BLANK=1.
- Line: across one visible line,
  - PIX_REQ is high for 4 consecutive cycles with PIX_X=0,1,2,3, then low for 4.
  - VGA_HS is low for exactly 2 cycles, starting 5+2 cycles after LINE_START.
- Frame:
  - FRAME_START period is 48 cycles.
  - VGA_VS is low for 8 consecutive cycles, starting 2 cycles after the LINE_START of line 4.
  - PIX_REQ is asserted 12 times per frame.
- Alignment:
  - With LATENCY=2, VGA_BLANK equals PIX_REQ delayed by 2 cycles over 3 full frames.
  - Rebuild with LATENCY=0: VGA_BLANK equals PIX_REQ exactly.
- Polarity: rebuild with HS_POL=1 and VS_POL=1. VGA_HS is high for 2 cycles per line and VGA_VS is high for 8 cycles per frame; both are low otherwise.
- Mid-frame reset: pulse RST for 1 cycle at hc=2, vc=1.
  - Required: outputs go to their reset values.
  - Required: the next edge gives FRAME_START=1, PIX_Y=0.
  - Required: no stray VGA_HS pulse and no VGA_BLANK=1 during the 2 delayed cycles.
